// File: rtl/jesd204b_rx_char_replace.sv
// Lane-0 JESD204B RX post-link stage: multiframe lock on first /A/,
// /F/ and /A/ character replacement, and /A/ position monitoring.
module jesd204b_rx_char_replace #(
    parameter int K_OCTETS      = 8,
    parameter int ERR_THRESH    = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     i_data_clk,
    input  logic                     i_rst,
    input  logic                     i_link_ok,
    input  logic [31:0]              i_data,
    input  logic [3:0]               i_charisk,
    output logic                     o_valid,
    output logic [31:0]              o_data,
    output logic [3:0]               o_mf_start,
    output logic                     o_locked,
    output logic                     o_realign_req,
    output logic [ERR_CNT_WIDTH-1:0] o_err_cnt
);

    localparam int BW = $clog2(K_OCTETS);

    typedef enum logic [1:0] {IDLE, WAIT_A, LOCKED, ALARM} state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            base_q, base_d;
    logic [7:0]               align_q, align_d;
    logic [ERR_CNT_WIDTH-1:0] err_q, err_d;
    logic [7:0]               prev_q, prev_d;
    logic [31:0]              data_q, data_d;
    logic                     valid_q, valid_d;
    logic [3:0]               mf_q, mf_d;
    logic                     locked_q, realign_q;

    logic                     run;
    logic [7:0]               oct, last;
    logic [2:0]               na, nk;
    logic                     lock_hit;
    int                       lock_n;
    int                       p, b, s;
    logic [ERR_CNT_WIDTH:0]   esum;
    logic [BW-1:0]            pos [4];
    logic                     is_a, is_f;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        align_d  = align_q;
        err_d    = err_q;
        data_d   = '0;
        valid_d  = 1'b0;
        mf_d     = '0;
        na       = '0;
        nk       = '0;
        lock_hit = 1'b0;
        lock_n   = 0;
        p        = 0;
        b        = 0;
        s        = 0;
        esum     = '0;
        oct      = '0;
        is_a     = 1'b0;
        is_f     = 1'b0;
        run      = (state_q == LOCKED) || (state_q == ALARM);
        last     = prev_q;

        for (int n = 0; n < 4; n++) begin
            p = int'(base_q) + n;
            if (p >= K_OCTETS) p = p - K_OCTETS;
            pos[n] = BW'(p);
            oct  = i_data[8*n +: 8];
            is_a = i_charisk[n] && (oct == 8'h7C);
            is_f = i_charisk[n] && (oct == 8'hFC);
            if (is_a && !lock_hit) begin
                lock_hit = 1'b1;
                lock_n   = n;
            end
            if (run && is_a && (p != K_OCTETS - 1)) na = na + 3'd1;
            if (run && i_charisk[n] && !is_a && !is_f) nk = nk + 3'd1;
            // Control octets repeat the last user value, chaining across words
            if (is_a || is_f || (run && i_charisk[n])) oct = last;
            data_d[8*n +: 8] = oct;
            last = oct;
        end
        prev_d = last;

        if (!i_link_ok) begin
            state_d = IDLE;
            align_d = '0;
            prev_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = WAIT_A;
                end
                WAIT_A: begin
                    if (lock_hit) begin
                        // Base of the following word: locking octet sits at K-1
                        b = K_OCTETS + 3 - lock_n;
                        if (b >= K_OCTETS) b = b - K_OCTETS;
                        base_d  = BW'(b);
                        align_d = '0;
                        state_d = LOCKED;
                    end
                end
                LOCKED, ALARM: begin
                    valid_d = 1'b1;
                    b = int'(base_q) + 4;
                    if (b >= K_OCTETS) b = b - K_OCTETS;
                    base_d = BW'(b);
                    s = int'(align_q) + int'(na);
                    if (s > 255) s = 255;
                    align_d = 8'(s);
                    esum = {1'b0, err_q} + (ERR_CNT_WIDTH+1)'(na + nk);
                    err_d = esum[ERR_CNT_WIDTH] ? '1 : esum[ERR_CNT_WIDTH-1:0];
                    if (s >= ERR_THRESH) state_d = ALARM;
                end
                default: state_d = IDLE;
            endcase
        end

        for (int n = 0; n < 4; n++)
            mf_d[n] = valid_d && (pos[n] == '0);
    end

    always_ff @(posedge i_data_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            align_q   <= '0;
            err_q     <= '0;
            prev_q    <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            mf_q      <= '0;
            locked_q  <= 1'b0;
            realign_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            align_q   <= align_d;
            err_q     <= err_d;
            prev_q    <= prev_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            mf_q      <= mf_d;
            locked_q  <= (state_d == LOCKED) || (state_d == ALARM);
            realign_q <= (state_d == ALARM);
        end
    end

    assign o_valid       = valid_q;
    assign o_data        = data_q;
    assign o_mf_start    = mf_q;
    assign o_locked      = locked_q;
    assign o_realign_req = realign_q;
    assign o_err_cnt     = err_q;

endmodule

// File: tb/tb_jesd204b_rx_char_replace.sv
// Directed-vector bench for jesd204b_rx_char_replace (K=8, threshold 4),
// with a second 4-bit error-counter instance sharing the same stream.
module tb_jesd204b_rx_char_replace;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        link_ok = 1'b0;
    logic [31:0] din = '0;
    logic [3:0]  kin = '0;

    logic        valid, locked, realign;
    logic [31:0] dout;
    logic [3:0]  mf;
    logic [7:0]  err;

    logic        s_valid, s_locked, s_realign;
    logic [31:0] s_dout;
    logic [3:0]  s_mf;
    logic [3:0]  s_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    jesd204b_rx_char_replace #(.K_OCTETS(8), .ERR_THRESH(4), .ERR_CNT_WIDTH(8)) dut (
        .i_data_clk(clk), .i_rst(rst), .i_link_ok(link_ok),
        .i_data(din), .i_charisk(kin),
        .o_valid(valid), .o_data(dout), .o_mf_start(mf),
        .o_locked(locked), .o_realign_req(realign), .o_err_cnt(err)
    );

    jesd204b_rx_char_replace #(.K_OCTETS(8), .ERR_THRESH(4), .ERR_CNT_WIDTH(4)) dut_s (
        .i_data_clk(clk), .i_rst(rst), .i_link_ok(link_ok),
        .i_data(din), .i_charisk(kin),
        .o_valid(s_valid), .o_data(s_dout), .o_mf_start(s_mf),
        .o_locked(s_locked), .o_realign_req(s_realign), .o_err_cnt(s_err)
    );

    task automatic step(input logic [31:0] d, input logic [3:0] k);
        @(negedge clk);
        din = d;
        kin = k;
        @(posedge clk);
        #1;
    endtask

    task automatic relock();
        @(negedge clk);
        rst = 1'b1;
        link_ok = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        link_ok = 1'b1;
        step(32'h0, 4'b0000);
        step(32'h7C000000, 4'b1000);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
        vectors++; if (dout !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", dout); end
        vectors++; if (mf !== 4'h0) begin miscompares++; $display("FAIL reset_mf got %b want 0", mf); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got %b want 0", locked); end
        vectors++; if (realign !== 1'b0) begin miscompares++; $display("FAIL reset_realign got %b want 0", realign); end
        vectors++; if (err !== 8'h0) begin miscompares++; $display("FAIL reset_err got %h want 0", err); end
    endtask

    task automatic test_lock();
        @(negedge clk);
        rst = 1'b0;
        link_ok = 1'b1;
        step(32'h0, 4'b0000);
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL prelock_locked got %b want 0", locked); end
        step(32'h7C443322, 4'b1000);
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL lock_valid got %b want 0", valid); end
        vectors++; if (dout !== 32'h44443322) begin miscompares++; $display("FAIL lock_data got %h want 44443322", dout); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_locked got %b want 1", locked); end
        step(32'h04030201, 4'b0000);
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL w1_valid got %b want 1", valid); end
        vectors++; if (dout !== 32'h04030201) begin miscompares++; $display("FAIL w1_data got %h want 04030201", dout); end
        vectors++; if (mf !== 4'b0001) begin miscompares++; $display("FAIL w1_mf got %b want 0001", mf); end
        step(32'h08070605, 4'b0000);
        vectors++; if (mf !== 4'b0000) begin miscompares++; $display("FAIL w2_mf got %b want 0000", mf); end
        step(32'h0C0B0A09, 4'b0000);
        vectors++; if (mf !== 4'b0001) begin miscompares++; $display("FAIL w3_mf got %b want 0001", mf); end
        step(32'h100F0E0D, 4'b0000);
        vectors++; if (mf !== 4'b0000) begin miscompares++; $display("FAIL w4_mf got %b want 0000", mf); end
    endtask

    task automatic test_f_chain();
        step(32'hFCFC11AA, 4'b1100);
        vectors++; if (dout !== 32'h111111AA) begin miscompares++; $display("FAIL fchain1_data got %h want 111111AA", dout); end
        vectors++; if (mf !== 4'b0001) begin miscompares++; $display("FAIL fchain1_mf got %b want 0001", mf); end
        step(32'h550000FC, 4'b0001);
        vectors++; if (dout !== 32'h55000011) begin miscompares++; $display("FAIL fchain2_data got %h want 55000011", dout); end
        vectors++; if (err !== 8'd0) begin miscompares++; $display("FAIL fchain_err got %0d want 0", err); end
    endtask

    task automatic test_unexpected_k();
        relock();
        step(32'h3344BC22, 4'b0010);
        vectors++; if (dout !== 32'h33442222) begin miscompares++; $display("FAIL unk_data got %h want 33442222", dout); end
        vectors++; if (err !== 8'd1) begin miscompares++; $display("FAIL unk_err got %0d want 1", err); end
        vectors++; if (realign !== 1'b0) begin miscompares++; $display("FAIL unk_realign got %b want 0", realign); end
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL unk_valid got %b want 1", valid); end
    endtask

    task automatic test_misalign();
        relock();
        for (int i = 0; i < 4; i++) begin
            step(32'h117C2233, 4'b0100);
            vectors++; if (dout !== 32'h11222233) begin miscompares++; $display("FAIL mis%0d_data got %h want 11222233", i, dout); end
            vectors++; if (err !== 8'(i + 1)) begin miscompares++; $display("FAIL mis%0d_err got %0d want %0d", i, err, i + 1); end
            vectors++; if (realign !== (i == 3)) begin miscompares++; $display("FAIL mis%0d_realign got %b want %b", i, realign, i == 3); end
            if (i < 3) step(32'h0, 4'b0000);
        end
        step(32'h0, 4'b0000);
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL alarm_valid got %b want 1", valid); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL alarm_locked got %b want 1", locked); end
        @(negedge clk);
        link_ok = 1'b0;
        step(32'h0, 4'b0000);
        vectors++; if (realign !== 1'b0) begin miscompares++; $display("FAIL drop_realign got %b want 0", realign); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL drop_locked got %b want 0", locked); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL drop_valid got %b want 0", valid); end
        vectors++; if (err !== 8'd4) begin miscompares++; $display("FAIL drop_err got %0d want 4", err); end
    endtask

    task automatic test_relock_phase();
        @(negedge clk);
        link_ok = 1'b1;
        step(32'h0, 4'b0000);
        step(32'h7C557C11, 4'b1010);
        vectors++; if (dout !== 32'h55551111) begin miscompares++; $display("FAIL relock_data got %h want 55551111", dout); end
        vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL relock_locked got %b want 1", locked); end
        step(32'h0, 4'b0000);
        vectors++; if (mf !== 4'b0000) begin miscompares++; $display("FAIL relock_mf1 got %b want 0000", mf); end
        step(32'h0, 4'b0000);
        vectors++; if (mf !== 4'b0100) begin miscompares++; $display("FAIL relock_mf2 got %b want 0100", mf); end
        vectors++; if (err !== 8'd4) begin miscompares++; $display("FAIL relock_err got %0d want 4", err); end
        vectors++; if (realign !== 1'b0) begin miscompares++; $display("FAIL relock_realign got %b want 0", realign); end
    endtask

    task automatic test_saturation();
        relock();
        for (int i = 0; i < 5; i++) step(32'hBCBCBCBC, 4'b1111);
        vectors++; if (s_err !== 4'hF) begin miscompares++; $display("FAIL sat_err4 got %0d want 15", s_err); end
        vectors++; if (err !== 8'd20) begin miscompares++; $display("FAIL sat_err8 got %0d want 20", err); end
        vectors++; if (dout !== 32'h0) begin miscompares++; $display("FAIL sat_data got %h want 0", dout); end
        vectors++; if (realign !== 1'b0) begin miscompares++; $display("FAIL sat_realign got %b want 0", realign); end
    endtask

    task automatic test_async_reset();
        relock();
        step(32'hDEADBEEF, 4'b0000);
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL prerst_valid got %b want 1", valid); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %b want 0", valid); end
        vectors++; if (dout !== 32'h0) begin miscompares++; $display("FAIL arst_data got %h want 0", dout); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL arst_locked got %b want 0", locked); end
        vectors++; if (mf !== 4'h0) begin miscompares++; $display("FAIL arst_mf got %b want 0", mf); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(32'h12345678, 4'b0000);
            vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL norelock%0d_valid got %b want 0", i, valid); end
        end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL norelock_locked got %b want 0", locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_f_chain();
        test_unexpected_k();
        test_misalign();
        test_relock_phase();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jesd204b_rx_char_replace.md
# jesd204b_rx_char_replace

Lane-0 post-link stage. It sits directly downstream of the JESD204B RX link core and consumes its 32-bit, 4-octet-per-clock lane stream once the link is up. For F=1 links it locks to the multiframe using the first /A/ (K28.3), replaces /F/ (K28.7) and /A/ control characters with the previous frame's octet, and monitors /A/ position against the multiframe. If alignment errors exceed a threshold, it raises a realign request.

## Interface
- K_OCTETS, 8: octets per multiframe (F=1 so frames = octets); multiple of 4, range 4..32.
- ERR_THRESH, 4: alignment errors since lock that trigger o_realign_req; 1..255.
- ERR_CNT_WIDTH, 8: width of o_err_cnt.

Ports:
- i_data_clk  in  1  link data clock (rxusrclk2 domain); the only clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_link_ok  in  1  high while the RX core reports CGS/ILAS done.
- i_data  in  32  lane octets; [7:0] is oldest (lane index 0), [31:24] newest (index 3).
- i_charisk  in  4  per-octet K-character flag; bit n qualifies octet n.
- o_valid  out  1  o_data holds user octets.
- o_data  out  32  replaced octets, same ordering as i_data.
- o_mf_start  out  4  one-hot: octet n is the first octet of a multiframe.
- o_locked  out  1  state is LOCKED or ALARM.
- o_realign_req  out  1  error threshold reached; request nsync re-assertion.
- o_err_cnt  out  ERR_CNT_WIDTH  saturating total error count since reset.

## Operation
- States: IDLE, WAIT_A, LOCKED, ALARM. Reset enters IDLE.
  - IDLE -> WAIT_A when i_link_ok=1.
  - Any state -> IDLE when i_link_ok=0. This has priority over all other transitions.
- Octet position: pos(n) = (base + n) mod K_OCTETS, where base is a $clog2(K_OCTETS)-bit register. In LOCKED and ALARM, base advances by 4 mod K each cycle.
- Locking in WAIT_A:
  - Locking octet: the lowest octet n with charisk=1 and data=0x7C.
  - On lock, base is set so that pos(n) = K-1. State goes to LOCKED, and the internal alignment error count is cleared.
  - Any other /A/ in the same word is ignored.
  - The locking word is output with o_valid=0.
- Replacement (WAIT_A, LOCKED, ALARM):
  - An octet with charisk=1 and data 0xFC or 0x7C is output as the previous octet's output value.
  - For octet 0, the previous octet is prev (octet 3 of the previous output word).
  - Replacement chains: consecutive control octets all take the last non-control value.
  - prev = 0x00 on reset and in IDLE.
- Errors (LOCKED/ALARM only), counted per octet, up to 4 per cycle:
  - Alignment error: /A/ at pos != K-1.
  - Unexpected-K error: charisk=1 with data other than 0xFC/0x7C. The octet is replaced as above.
  - Both kinds add to o_err_cnt, which saturates at all-ones and is cleared only by i_rst.
  - Only alignment errors add to the internal align_err count, which saturates at 255.
- LOCKED -> ALARM when align_err (including this cycle's errors) >= ERR_THRESH.
- In ALARM, o_realign_req=1 and o_valid=1 continue until i_link_ok=0.
- o_mf_start bit n = 1 when pos(n)=0 and the word is valid.

## Timing
- One register stage: o_data, o_valid, and o_mf_start follow i_data by exactly 1 cycle.
- o_valid(t+1) = 1 iff the state was LOCKED or ALARM during cycle t and i_link_ok(t)=1.
- o_locked, o_realign_req, and o_err_cnt are registered and update in the same edge as the data of the word that caused them.
- Reset values: o_valid=0, o_data=0, o_mf_start=0, o_locked=0, o_realign_req=0, o_err_cnt=0, base=0, prev=0.
- i_link_ok falling during a word: that word is output with o_valid=0, the state is IDLE next cycle, and align_err is cleared.
- i_rst asserted mid-stream: all outputs clear asynchronously. After release, the block needs i_link_ok plus a new /A/ to relock.
- A relock after IDLE recomputes base from scratch and does not reuse the old phase.

## Test plan
- Basic lock: K=8, link_ok=1. Word 0x7C443322 with charisk=0b1000 locks. Next cycle: o_valid=0, o_data=0x44443322, o_locked=1. Following words: o_valid=1, and o_mf_start=0b0001 every 2nd word.
- /F/ chain: locked; word 0xFCFC11AA with charisk=0b1100 -> o_data=0x1111 11AA (0x111111AA). Then word 0x550000FC with charisk=0b0001 -> octet 0 = 0x11.
- Misalignment: locked, ERR_THRESH=4. Four /A/ at pos 2 -> o_err_cnt=4, o_realign_req=1 one cycle after the 4th, state ALARM. Dropping link_ok -> o_realign_req=0, o_locked=0 next cycle.
- Unexpected K: locked; 0xBC with charisk on octet 1 -> o_err_cnt +1, octet replaced by octet 0, o_realign_req stays 0.
- Saturation: ERR_CNT_WIDTH=4, inject 20 unexpected-K octets -> o_err_cnt holds at 15.
- Async reset mid-stream: assert i_rst between edges -> all outputs 0 immediately. Release with link_ok=1 and no /A/ -> o_valid stays 0.
